// File: rtl/eros_mem_pkg.sv
// Bank power-state encoding and small elaboration helpers.
package eros_mem_pkg;

   typedef enum logic [1:0] {
      PWR_ON   = 2'd0,
      PWR_GATE = 2'd1,
      PWR_OFF  = 2'd2,
      PWR_WAKE = 2'd3
   } pwr_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/eros_obi_pkg.sv
// OBI request/response payloads shared by the memory subsystem ports.
package eros_obi_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

// File: rtl/mem_bank_pwr_ctrl.sv
// Per-bank power FSM (ON/GATE/OFF/WAKE) with saturating dwell counter and retention handling.
// Grants are combinational in ON; rvalid follows one cycle after each grant.
module mem_bank_pwr_ctrl
   import eros_mem_pkg::*;
#(
   parameter int WAKE_CYCLES = 4,
   parameter int ACK_TIMEOUT = 16,
   parameter int AUTO_WAKE   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       pwr_off_req,
   input  logic       retentive_req,
   input  logic       pwrgate_ack_n,
   output logic       gnt,
   output logic       mem_req,
   output logic       pwrgate_n,
   output logic       set_retentive_n,
   output logic       rvalid,
   output pwr_state_e state
);
   localparam int CNT_W = $clog2(max_int(WAKE_CYCLES, ACK_TIMEOUT) + 1);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;
   logic             ret_q;

   // ret_q marks that the macro sat in retention last cycle, costing one grant on exit.
   always_comb begin
      gnt             = (state == PWR_ON) && req && !ret_q;
      mem_req         = gnt;
      pwrgate_n       = !((state == PWR_GATE) || (state == PWR_OFF));
      set_retentive_n = !((state == PWR_ON) && retentive_req && !req);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= PWR_ON;
         cnt    <= '0;
         ret_q  <= 1'b0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= gnt;
         ret_q  <= !set_retentive_n;
         case (state)
            PWR_ON: begin
               if (pwr_off_req && !req && !rvalid) begin
                  state <= PWR_GATE;
                  cnt   <= '0;
               end
            end
            PWR_GATE: begin
               if (!pwrgate_ack_n || (cnt >= ACK_LAST)) begin
                  state <= PWR_OFF;
                  cnt   <= '0;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            PWR_OFF: begin
               if (!pwr_off_req || ((AUTO_WAKE != 0) && req)) begin
                  state <= PWR_WAKE;
                  cnt   <= '0;
               end
            end
            PWR_WAKE: begin
               if ((cnt >= WAKE_LAST) && pwrgate_ack_n) begin
                  state <= PWR_ON;
                  cnt   <= '0;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= PWR_ON;
         endcase
      end
   end

endmodule

// File: rtl/sram_wrapper.sv
// Power-gateable single-port 32-bit SRAM macro: one-cycle registered read, byte-enabled write.
// Acks a power-down (pwrgate_ack_n=0) once pwrgate_n has been low for ACK_DELAY cycles.
module sram_wrapper #(
   parameter int WORDS     = 8192,
   parameter int ACK_DELAY = 3,
   parameter bit NEVER_ACK = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        pwrgate_n,
   input  logic        set_retentive_n,
   output logic        pwrgate_ack_n
);
   localparam int AW = $clog2(WORDS);
   localparam int DW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
   localparam logic [DW-1:0] ACK_LAST = DW'(ACK_DELAY - 1);

   logic [31:0]   mem [WORDS];
   logic [AW-1:0] widx;
   logic          access;
   logic [DW-1:0] mcnt;
   logic          unused_addr_bits;

   assign widx             = addr[AW+1:2];
   assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
   assign access           = req && pwrgate_n && set_retentive_n;

   always_ff @(posedge clk) begin
      if (access && we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (access && !we) rdata <= mem[widx];
   end

   // Cycles spent with the supply gated, saturating at the ack point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 mcnt <= '0;
      else if (pwrgate_n)      mcnt <= '0;
      else if (mcnt != ACK_LAST) mcnt <= mcnt + 1'b1;
   end

   assign pwrgate_ack_n = NEVER_ACK || pwrgate_n || (mcnt != ACK_LAST);

endmodule

// File: rtl/banked_memory_sys.sv
// NUM_BANKS independent power-managed SRAM banks, each behind its own OBI port.
// A bank only accepts requests in ON; elsewhere gnt stays low and the requester waits.
module banked_memory_sys
   import eros_obi_pkg::*;
   import eros_mem_pkg::*;
#(
   parameter int                   NUM_BANKS   = 2,
   parameter int                   BANK_WORDS  = 8192,
   parameter int                   WAKE_CYCLES = 4,
   parameter int                   ACK_TIMEOUT = 16,
   parameter int                   AUTO_WAKE   = 1,
   parameter int                   ACK_DELAY   = 3,
   parameter logic [NUM_BANKS-1:0] NO_ACK_MASK = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  obi_req_t               ram_req_i [NUM_BANKS],
   output obi_resp_t              ram_resp_o [NUM_BANKS],
   input  logic [NUM_BANKS-1:0]   pwr_off_req_i,
   input  logic [NUM_BANKS-1:0]   retentive_req_i,
   output logic [2*NUM_BANKS-1:0] bank_state_o,
   output logic [NUM_BANKS-1:0]   bank_ready_o
);

   for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      logic        gnt;
      logic        mem_req;
      logic        pwrgate_n;
      logic        set_retentive_n;
      logic        pwrgate_ack_n;
      logic        rvalid;
      logic [31:0] rdata;
      pwr_state_e  state;

      mem_bank_pwr_ctrl #(
         .WAKE_CYCLES (WAKE_CYCLES),
         .ACK_TIMEOUT (ACK_TIMEOUT),
         .AUTO_WAKE   (AUTO_WAKE)
      ) u_ctrl (
         .clk             (clk_i),
         .rst             (rst_i),
         .req             (ram_req_i[i].req),
         .pwr_off_req     (pwr_off_req_i[i]),
         .retentive_req   (retentive_req_i[i]),
         .pwrgate_ack_n   (pwrgate_ack_n),
         .gnt             (gnt),
         .mem_req         (mem_req),
         .pwrgate_n       (pwrgate_n),
         .set_retentive_n (set_retentive_n),
         .rvalid          (rvalid),
         .state           (state)
      );

      sram_wrapper #(
         .WORDS     (BANK_WORDS),
         .ACK_DELAY (ACK_DELAY),
         .NEVER_ACK (NO_ACK_MASK[i])
      ) u_sram (
         .clk             (clk_i),
         .rst             (rst_i),
         .req             (mem_req),
         .we              (ram_req_i[i].we),
         .be              (ram_req_i[i].be),
         .addr            (ram_req_i[i].addr),
         .wdata           (ram_req_i[i].wdata),
         .rdata           (rdata),
         .pwrgate_n       (pwrgate_n),
         .set_retentive_n (set_retentive_n),
         .pwrgate_ack_n   (pwrgate_ack_n)
      );

      assign ram_resp_o[i]          = '{gnt: gnt, rvalid: rvalid, rdata: rdata};
      assign bank_state_o[2*i +: 2] = state;
      assign bank_ready_o[i]        = (state == PWR_ON);
   end

endmodule

// File: tb/tb_banked_memory_sys.sv
// Directed bench for banked_memory_sys: bank1 never acks power-down so the timeout path is exercised.
module tb_banked_memory_sys;
   import eros_obi_pkg::*;

   localparam logic [1:0] S_ON = 2'd0, S_GATE = 2'd1, S_OFF = 2'd2, S_WAKE = 2'd3;

   logic       clk = 1'b0;
   logic       rst;
   obi_req_t   ram_req [2];
   obi_resp_t  ram_resp [2];
   logic [1:0] pwr_off;
   logic [1:0] ret;
   logic [3:0] bank_state;
   logic [1:0] bank_ready;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   banked_memory_sys #(
      .NUM_BANKS   (2),
      .BANK_WORDS  (16),
      .WAKE_CYCLES (4),
      .ACK_TIMEOUT (16),
      .AUTO_WAKE   (1),
      .ACK_DELAY   (3),
      .NO_ACK_MASK (2'b10)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .ram_req_i       (ram_req),
      .ram_resp_o      (ram_resp),
      .pwr_off_req_i   (pwr_off),
      .retentive_req_i (ret),
      .bank_state_o    (bank_state),
      .bank_ready_o    (bank_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input int b, input logic r, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
      ram_req[b].req   = r;
      ram_req[b].we    = we;
      ram_req[b].be    = be;
      ram_req[b].addr  = addr;
      ram_req[b].wdata = wdata;
   endtask

   task automatic idle(input int b);
      drive(b, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic wait_state(input int b, input logic [1:0] st, input int budget, input string tag);
      int n = 0;
      while (bank_state[2*b +: 2] !== st && n < budget) begin
         next();
         #1;
         n++;
      end
      chk(tag, bank_state[2*b +: 2], st);
   endtask

   initial begin
      rst = 1'b0; pwr_off = 2'b00; ret = 2'b00;
      idle(0); idle(1);
      #1 rst = 1'b1;
      next();

      // Reset state: all ON, gnt tracks req, no rvalid.
      drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      #1;
      chk("rst_ready", bank_ready, 2'b11);
      chk("rst_state", bank_state, 4'h0);
      chk("rst_gnt_follows_req", ram_resp[0].gnt, 1'b1);
      chk("rst_gnt_idle", ram_resp[1].gnt, 1'b0);
      chk("rst_rvalid", ram_resp[0].rvalid, 1'b0);
      chk("rst_pwrgate_n", dut.g_bank[0].pwrgate_n, 1'b1);
      chk("rst_set_ret_n", dut.g_bank[0].set_retentive_n, 1'b1);
      next();
      idle(0); rst = 1'b0;
      next();

      // Write then read back, including a byte-enabled partial write.
      drive(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      #1 chk("wr_gnt", ram_resp[0].gnt, 1'b1);
      next();
      drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      #1 chk("wr_rvalid", ram_resp[0].rvalid, 1'b1);
      chk("rd_gnt", ram_resp[0].gnt, 1'b1);
      next();
      drive(0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'h0000AAAA);
      #1 chk("rd_rvalid", ram_resp[0].rvalid, 1'b1);
      chk("rd_rdata", ram_resp[0].rdata, 32'hDEADBEEF);
      next();
      drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      next();
      idle(0);
      drive(1, 1'b1, 1'b1, 4'hF, 32'h1000_0014, 32'h12345678);
      #1 chk("be_rdata", ram_resp[0].rdata, 32'hDEADAAAA);
      chk("be_rvalid", ram_resp[0].rvalid, 1'b1);
      next();
      drive(1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
      next();
      idle(1);
      #1 chk("hiaddr_rvalid", ram_resp[1].rvalid, 1'b1);
      chk("hiaddr_rdata", ram_resp[1].rdata, 32'h12345678);
      next();

      // Retention: idle holds retention, request costs one ungranted cycle.
      ret = 2'b01;
      #1 chk("ret_idle_n", dut.g_bank[0].set_retentive_n, 1'b0);
      chk("ret_other_bank", dut.g_bank[1].set_retentive_n, 1'b1);
      next();
      drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      #1 chk("ret_exit_gnt", ram_resp[0].gnt, 1'b0);
      chk("ret_exit_n", dut.g_bank[0].set_retentive_n, 1'b1);
      next();
      #1 chk("ret_next_gnt", ram_resp[0].gnt, 1'b1);
      chk("ret_no_rvalid", ram_resp[0].rvalid, 1'b0);
      next();
      idle(0); ret = 2'b00;
      #1 chk("ret_rvalid", ram_resp[0].rvalid, 1'b1);
      chk("ret_rdata", ram_resp[0].rdata, 32'hDEADAAAA);
      next();

      // Power-down both banks: bank0 acked after 3 GATE cycles, bank1 times out after 16.
      pwr_off = 2'b11;
      #1 chk("pd_start_state", bank_state, 4'h0);
      for (int c = 1; c <= 17; c++) begin
         next();
         #1;
         if (c == 1) chk("pd_b0_pwrgate_n", dut.g_bank[0].pwrgate_n, 1'b0);
         if (c == 3) chk("pd_b0_gate3", bank_state[1:0], S_GATE);
         if (c == 4) chk("pd_b0_off", bank_state[1:0], S_OFF);
         if (c == 16) chk("pd_b1_gate16", bank_state[3:2], S_GATE);
         if (c == 17) chk("pd_b1_off", bank_state[3:2], S_OFF);
      end

      // Bank0 wakes on pwr_off_req release: 4 WAKE cycles then ON.
      pwr_off = 2'b10;
      for (int c = 1; c <= 5; c++) begin
         next();
         #1;
         if (c == 1) chk("wk_b0_wake", bank_state[1:0], S_WAKE);
         if (c == 1) chk("wk_b0_pwrgate_n", dut.g_bank[0].pwrgate_n, 1'b1);
         if (c == 4) chk("wk_b0_wake4", bank_state[1:0], S_WAKE);
         if (c == 5) chk("wk_b0_ready", bank_ready, 2'b01);
      end

      // Auto-wake on bank1: held request is not granted until the first ON cycle.
      drive(1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
      #1 chk("aw_off_gnt", ram_resp[1].gnt, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         next();
         #1;
         if (c == 1) chk("aw_wake", bank_state[3:2], S_WAKE);
         if (c <= 4) chk("aw_wake_gnt", ram_resp[1].gnt, 1'b0);
         if (c == 5) chk("aw_on_gnt", ram_resp[1].gnt, 1'b1);
      end
      next();
      idle(1); pwr_off = 2'b00;
      #1 chk("aw_rvalid", ram_resp[1].rvalid, 1'b1);
      chk("aw_rdata", ram_resp[1].rdata, 32'h12345678);
      next();

      // Power-off and request in the same cycle: request wins, then GATE.
      pwr_off = 2'b01;
      drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      #1 chk("race_gnt", ram_resp[0].gnt, 1'b1);
      next();
      idle(0);
      #1 chk("race_rvalid", ram_resp[0].rvalid, 1'b1);
      chk("race_rdata", ram_resp[0].rdata, 32'hDEADAAAA);
      chk("race_still_on", bank_state[1:0], S_ON);
      next();
      next();
      #1 chk("race_gate", bank_state[1:0], S_GATE);
      wait_state(0, S_OFF, 8, "race_off");

      // Reset while bank1 is mid-WAKE and bank0 has a read in flight.
      pwr_off = 2'b10;
      wait_state(0, S_ON, 10, "pre_rst_b0_on");
      wait_state(1, S_OFF, 25, "pre_rst_b1_off");
      pwr_off = 2'b00;
      next();
      drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      #1 chk("mid_b1_wake", bank_state[3:2], S_WAKE);
      chk("mid_b0_gnt", ram_resp[0].gnt, 1'b1);
      next();
      #1 chk("mid_b0_rvalid", ram_resp[0].rvalid, 1'b1);
      rst = 1'b1;
      #1 chk("mid_rst_rvalid", ram_resp[0].rvalid, 1'b0);
      chk("mid_rst_ready", bank_ready, 2'b11);
      chk("mid_rst_state", bank_state, 4'h0);
      next();
      rst = 1'b0; idle(0);
      #1 chk("post_rst_rvalid0", ram_resp[0].rvalid, 1'b0);
      chk("post_rst_rvalid1", ram_resp[1].rvalid, 1'b0);
      next();
      #1 chk("post_rst_stale", ram_resp[0].rvalid, 1'b0);
      chk("post_rst_ready", bank_ready, 2'b11);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
